// File: rtl/apb3_master_arbiter.sv
// APB3 master shared by N_REQ requesters. Requesters are granted round-robin,
// and each transfer runs through the APB SETUP and ACCESS phases. Read data and
// the error status come back on a one-cycle response strobe.
// Optional build macro APB3_ARB_TIMEOUT_EN: aborts ACCESS after TIMEOUT_CYCLES
// cycles without PREADY and reports the transfer with rsp_err.
//
// state  | meaning
// IDLE   | no transfer on the bus; pick a winner and accept it
// SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
// ACCESS | PSEL=1, PENABLE=1 until PREADY (or timeout abort)
module apb3_master_arbiter #(
  parameter int N_REQ          = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic                        rsp_err,
  output logic                        PSEL,
  output logic                        PENABLE,
  output logic                        PWRITE,
  output logic [ADDR_WIDTH-1:0]       PADDR,
  output logic [DATA_WIDTH-1:0]       PWDATA,
  input  logic [DATA_WIDTH-1:0]       PRDATA,
  input  logic                        PREADY,
  input  logic                        PSLVERR
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] grant_reg;
  logic [GW-1:0] win_idx;
  logic          win_found;
  logic          accept;
  logic          done;
  logic          abort;

  // Round-robin search starting just above the previous winner, with wrap.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(last_grant) + 1 + k) % N_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = GW'(idx);
      end
    end
  end

  // Holding off acceptance while rst is low keeps req_ready at 0 during reset.
  assign accept = (state == IDLE) && win_found && rst;
  assign done   = (state == ACCESS) && PREADY;

`ifdef APB3_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt;

  // Wait-state counter; it sits at zero outside ACCESS so every ACCESS starts fresh.
  always_ff @(posedge clk) begin
    if (!rst)                 tcnt <= '0;
    else if (state != ACCESS) tcnt <= '0;
    else if (!PREADY)         tcnt <= tcnt + 1'b1;
  end

  assign abort = (state == ACCESS) && !PREADY && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES < 2);
  assign abort          = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic, APB phase controls and the combinational accept strobe.
  always_comb begin
    state_nxt = state;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready[win_idx] = 1'b1;
          state_nxt          = SETUP;
        end
      end
      SETUP: begin
        PSEL      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (done || abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer fields are captured at accept and cleared when the bus goes idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= GW'(N_REQ - 1);
      grant_reg  <= '0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (accept) begin
        grant_reg  <= win_idx;
        last_grant <= win_idx;
        PWRITE     <= req_write[win_idx];
        PADDR      <= req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        PWDATA     <= req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      end else if (done || abort) begin
        rsp_valid[grant_reg] <= 1'b1;
        rsp_rdata            <= (abort || PWRITE) ? '0 : PRDATA;
        rsp_err              <= abort ? 1'b1 : PSLVERR;
        PWRITE               <= 1'b0;
        PADDR                <= '0;
        PWDATA               <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb3_master_arbiter.sv
// Self-checking bench for apb3_master_arbiter: vector table plus hand-written
// sequences for phase timing, contention, reset mid-transfer and timeout.
module tb_apb3_master_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef APB3_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [DW-1:0]   PRDATA  = 32'hBADC0DE0;
  logic            PREADY  = 1'b0;
  logic            PSLVERR = 1'b1;

  apb3_master_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired, got no event want event", name);
  endtask

  // Scoreboard of expected responses, pushed at acceptance.
  typedef struct {
    int          r;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t sb[$];
  rsp_t mon_e;

  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        mon_e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'd1 << mon_e.r);
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  // Completer model plus bus stability checks.
  int          cur_waits  = 0;
  logic [31:0] cur_addr   = '0;
  logic [31:0] cur_wdata  = '0;
  logic [31:0] cur_prdata = '0;
  logic        cur_w      = 1'b0;
  logic        cur_serr   = 1'b0;
  int          wcnt       = 0;

  always @(negedge clk) begin
    check("ready_le1", 32'($countones(req_ready) <= 1), 32'd1);
    if (PSEL === 1'b1) begin
      check("paddr", PADDR, cur_addr);
      check("pwrite", 32'(PWRITE), 32'(cur_w));
      if (cur_w) check("pwdata", PWDATA, cur_wdata);
    end else begin
      check("idle_paddr", PADDR, 32'd0);
      check("idle_pwdata", PWDATA, 32'd0);
      check("idle_ctl", {30'd0, PENABLE, PWRITE}, 32'd0);
    end
    if (PSEL === 1'b1 && PENABLE === 1'b1) begin
      if (wcnt >= cur_waits) begin
        PREADY = 1'b1; PRDATA = cur_prdata; PSLVERR = cur_serr;
      end else begin
        PREADY = 1'b0; PRDATA = 32'hBADC0DE0; PSLVERR = 1'b1;
      end
      wcnt++;
    end else begin
      wcnt = 0; PREADY = 1'b0; PRDATA = 32'hBADC0DE0; PSLVERR = 1'b1;
    end
  end

  // Called just after a negedge; returns at posedge+1 of the accept edge.
  task automatic issue(input int r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int waits, input logic [31:0] prd, input logic serr,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    n = 0;
    req_valid[r] = 1'b1;
    req_write[r] = w;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = d;
    #1;
    while (req_ready[r] !== 1'b1 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      fail_bound("accept_wait");
      req_valid[r] = 1'b0;
      return;
    end
    check("ready_onehot", 32'(req_ready), 32'd1 << r);
    cur_addr = a; cur_w = w; cur_wdata = d; cur_waits = waits; cur_prdata = prd; cur_serr = serr;
    sb.push_back('{r, exp_rdata, exp_err});
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  // Counts negedges from the cycle after acceptance until rsp_valid.
  task automatic wait_rsp(input string name, input int exp_lat);
    int n;
    n = 1;
    @(negedge clk);
    while (rsp_valid === '0 && n < 3000) begin
      @(negedge clk); n++;
    end
    check(name, 32'(n), 32'(exp_lat));
  endtask

  typedef struct {
    int          r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        serr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int pen;
    int n;
    vecs[0] = '{0, 1'b1, 32'h10, 32'hA5A50001, 0, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 3};
    vecs[1] = '{1, 1'b0, 32'h20, 32'h0,        3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 6};
    vecs[2] = '{0, 1'b0, 32'h30, 32'h0,        0, 32'h12345678, 1'b1, 32'h12345678, 1'b1, 3};
    vecs[3] = '{1, 1'b1, 32'h34, 32'h0BADF00D, 1, 32'h55555555, 1'b0, 32'h0,        1'b0, 4};
    vecs[4] = '{1, 1'b0, 32'h40, 32'h0,        0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0, 3};
    vecs[5] = '{0, 1'b1, 32'h44, 32'h77778888, 2, 32'h0,        1'b1, 32'h0,        1'b1, 5};
    vecs[6] = '{0, 1'b0, 32'h48, 32'h0,        0, 32'h0,        1'b0, 32'h0,        1'b0, 3};

    // Reset state, with requests pending during reset.
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_psel", {30'd0, PSEL, PENABLE}, 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;

    // Single zero-wait write with phase timing.
    issue(0, 1'b1, 32'h10, 32'hA5A50001, 0, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t1_psel_penable", {30'd0, PSEL, PENABLE}, 32'b10);
    @(negedge clk);
    check("t2_psel_penable", {30'd0, PSEL, PENABLE}, 32'b11);
    @(negedge clk);
    check("t3_rsp_valid", 32'(rsp_valid), 32'b01);

    // Back-to-back: accepted in the same cycle as the previous response.
    issue(1, 1'b0, 32'h20, 32'h0, 3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
    wait_rsp("lat_read_3wait", 6);

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
            vecs[i].prdata, vecs[i].serr, vecs[i].exp_rdata, vecs[i].exp_err);
      wait_rsp("lat_vec", vecs[i].exp_lat);
    end

    // Reset during ACCESS after requester 0 won (pointer now favours 1).
    issue(0, 1'b0, 32'h60, 32'h0, 100000, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_rst_access", {30'd0, PSEL, PENABLE}, 32'b11);
    rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    check("midrst_psel", {30'd0, PSEL, PENABLE}, 32'd0);
    check("midrst_paddr", PADDR, 32'd0);
    check("midrst_pwdata", PWDATA, 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    req_write = '0;
    req_addr[0 +: AW]  = 32'h50;
    req_addr[AW +: AW] = 32'h54;
    req_valid = 2'b11;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Contention from reset: expect 0,1,0,1.
    #1;
    for (int k = 0; k < 4; k++) begin
      int g;
      n = 0;
      while (req_ready === '0 && n < 50) begin
        @(negedge clk); #1; n++;
      end
      if (n >= 50) begin
        fail_bound("contention_accept");
        break;
      end
      check("one_ready", 32'($countones(req_ready)), 32'd1);
      g = req_ready[1] ? 1 : 0;
      check("grant_order", 32'(g), 32'(k % 2));
      cur_addr = (g == 1) ? 32'h54 : 32'h50;
      cur_w = 1'b0; cur_waits = 0; cur_prdata = 32'h100 + 32'(k); cur_serr = 1'b0;
      sb.push_back('{g, 32'h100 + 32'(k), 1'b0});
      @(posedge clk); #1;
      if (k == 3) req_valid = '0;
      @(negedge clk); #1;
    end
    repeat (6) @(negedge clk);

`ifdef APB3_ARB_TIMEOUT_EN
    issue(0, 1'b0, 32'h70, 32'h0, 100000, 32'h13572468, 1'b0, 32'h0, 1'b1);
    pen = 0;
    n = 0;
    @(negedge clk);
    while (rsp_valid === '0 && n < 200) begin
      if (PENABLE === 1'b1) pen++;
      @(negedge clk); n++;
    end
    check("timeout_penable_cycles", 32'(pen), 32'd8);
    issue(1, 1'b1, 32'h74, 32'h00001234, 0, 32'h0, 1'b0, 32'h0, 1'b0);
    wait_rsp("lat_after_timeout", 3);
`else
    pen = 0;
    issue(0, 1'b0, 32'h70, 32'h0, 100000, 32'h13572468, 1'b0, 32'h0, 1'b0);
    repeat (1000) begin
      @(negedge clk);
      if (rsp_valid !== '0) pen++;
    end
    check("no_timeout_still_access", {30'd0, PSEL, PENABLE}, 32'b11);
    check("no_timeout_no_rsp", 32'(pen), 32'd0);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
